// File: rtl/fifo2frame_if.sv
// Line-FIFO read side and pixel stream bundle for fifo2frame.
// master: the unpacker (pops the FIFO, drives pixels); slave: FIFO + pixel sink.
interface fifo2frame_if #(
  parameter int unsigned ADDR_WIDTH = 5
) ();
  logic [63:0]           fifo_data;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] fifo_words_used;
  logic                  fifo_pop;
  logic [7:0]            pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_eof;

  modport master (
    input  fifo_data, fifo_empty, fifo_words_used, pix_ready,
    output fifo_pop, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_words_used, pix_ready,
    input  fifo_pop, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );
endinterface

// File: rtl/fifo2frame.sv
// fifo2frame: pops 64-bit words from the line FIFO, unpacks them into 8-bit pixels (byte 0
// first) and emits a raster-ordered pixel stream with SOF/EOL/EOF markers.
// Optional feature: define FIFO2FRAME_STARVE_CNT_EN to build the starvation counter;
// otherwise sts_starve_cnt is tied to 0.
module fifo2frame #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned STARVE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fifo2frame_if.master            bus,
  input  logic                    cfg_blk_en,
  input  logic [10:0]             cfg_img_width,
  input  logic [10:0]             cfg_img_height,
  output logic                    sts_done,
  output logic [STARVE_CNT_W-1:0] sts_starve_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        blk_en_q;
  logic [10:0] width_q, height_q;
  logic [10:0] x_q, y_q;
  logic [21:0] budget_q;
  logic [63:0] buf_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic [2:0]  byte_q;
  logic        pop_q;
  logic        done_q;

  logic        start, abort;
  logic [11:0] wpl;
  logic [21:0] budget_init;
  logic        valid, sof, eol, eof, last_x, last_y;
  logic [7:0]  data;
  logic        accept, word_free, pop, push;

  // Fill level is status only; it plays no part in control.
  logic [ADDR_WIDTH-1:0] unused_words_used;
  assign unused_words_used = bus.fifo_words_used;

  assign start       = cfg_blk_en & ~blk_en_q;
  assign abort       = ~cfg_blk_en;
  assign wpl         = ({1'b0, cfg_img_width} + 12'd7) >> 3;
  assign budget_init = 22'(wpl) * 22'(cfg_img_height);

  // Pixel presentation, markers, handshake and FIFO pop decision.
  always_comb begin
    valid     = (state_q == StRun) && (count_q != 2'd0);
    last_x    = (x_q == width_q - 11'd1);
    last_y    = (y_q == height_q - 11'd1);
    data      = valid ? buf_q[rd_ptr_q][{byte_q, 3'b000} +: 8] : 8'd0;
    sof       = valid && (x_q == 11'd0) && (y_q == 11'd0);
    eol       = valid && last_x;
    eof       = eol && last_y;
    accept    = valid && bus.pix_ready;
    // A word is released either at its last byte or at end of line (tail bytes discarded).
    word_free = accept && (last_x || (byte_q == 3'd7));
    pop       = (state_q == StRun) && !bus.fifo_empty && (budget_q != 22'd0) &&
                ((count_q + {1'b0, pop_q}) < 2'd2);
    // Data for a pop lands one cycle later; drop it if the frame was aborted meanwhile.
    push      = pop_q && (state_q == StRun) && cfg_blk_en;
  end

  assign bus.fifo_pop  = pop;
  assign bus.pix_data  = data;
  assign bus.pix_valid = valid;
  assign bus.pix_sof   = sof;
  assign bus.pix_eol   = eol;
  assign bus.pix_eof   = eof;
  assign sts_done      = done_q;

  // Frame control next state; disable overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && eof) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Config capture, word budget, 2-entry word buffer and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_en_q <= 1'b0;
      pop_q    <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      budget_q <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      byte_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      blk_en_q <= cfg_blk_en;
      pop_q    <= pop;
      if (abort) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= '0;
        byte_q   <= '0;
        done_q   <= 1'b0;
      end else if (start) begin
        width_q  <= cfg_img_width;
        height_q <= cfg_img_height;
        budget_q <= budget_init;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= '0;
        byte_q   <= '0;
        x_q      <= '0;
        y_q      <= '0;
        done_q   <= 1'b0;
      end else begin
        if (pop) budget_q <= budget_q - 22'd1;
        if (push) begin
          buf_q[wr_ptr_q] <= bus.fifo_data;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        case ({push, word_free})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: ;
        endcase
        if (accept) begin
          if (word_free) begin
            rd_ptr_q <= ~rd_ptr_q;
            byte_q   <= '0;
          end else begin
            byte_q   <= byte_q + 3'd1;
          end
          if (last_x) begin
            x_q <= '0;
            if (!last_y) y_q <= y_q + 11'd1;
          end else begin
            x_q <= x_q + 11'd1;
          end
          if (eof) done_q <= 1'b1;
        end
      end
    end
  end

`ifdef FIFO2FRAME_STARVE_CNT_EN
  logic [STARVE_CNT_W-1:0] starve_q;

  // Saturating count of cycles where the sink was ready but no pixel was available.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (start) begin
      starve_q <= '0;
    end else if ((state_q == StRun) && bus.pix_ready && !valid && !(&starve_q)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign sts_starve_cnt = starve_q;
`else
  assign sts_starve_cnt = '0;
`endif

endmodule
